// File: rtl/op_batch_feeder.sv
// Buffers host ALU operations in a FIFO and, on launch, streams a snapshot-sized
// batch to the downstream stage, then waits for its completion flag and result.
module op_batch_feeder #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_A,
  input  logic [7:0]               in_B,
  input  logic [3:0]               in_instr,
  input  logic                     launch,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     busy,
  output logic                     start,
  output logic                     valid,
  output logic [7:0]               data_A,
  output logic [7:0]               data_B,
  output logic [3:0]               instruction,
  output logic [7:0]               count,
  input  logic                     finish_in,
  input  logic [7:0]               third_in,
  output logic [7:0]               result,
  output logic                     done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_FIN} state_t;

  state_t          state_q;
  logic [AW:0]     left_q;
  logic            start_q, valid_q, done_q;
  logic [19:0]     data_q;
  logic [7:0]      count_q, result_q;

  logic [19:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     fill_q, fill_d;
  logic            push, pop;
  logic [19:0]     rd_word;

  assign in_ready = (fill_q != FULL);
  assign push     = in_valid && in_ready;
  // Pops are driven only by the batch countdown, so late pushes never join it.
  assign pop      = ((state_q == START) || (state_q == STREAM)) && (left_q != '0);
  assign rd_word  = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    fill_d   = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {in_A, in_B, in_instr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      left_q   <= '0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch && (fill_q != '0)) begin
            state_q <= START;
            start_q <= 1'b1;
            count_q <= 8'(fill_q);
            left_q  <= fill_q;
          end
        end
        START, STREAM: begin
          if (pop) begin
            state_q <= STREAM;
            valid_q <= 1'b1;
            data_q  <= rd_word;
            left_q  <= left_q - 1'b1;
          end else begin
            state_q <= WAIT_FIN;
            valid_q <= 1'b0;
            data_q  <= '0;
          end
        end
        WAIT_FIN: begin
          if (finish_in) begin
            state_q  <= IDLE;
            result_q <= third_in;
            done_q   <= 1'b1;
            count_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fill_level  = fill_q;
  assign busy        = (state_q != IDLE);
  assign start       = start_q;
  assign valid       = valid_q;
  assign data_A      = data_q[19:12];
  assign data_B      = data_q[11:4];
  assign instruction = data_q[3:0];
  assign count       = count_q;
  assign result      = result_q;
  assign done        = done_q;
endmodule
